usbf_rx_pack: RTL and testbench

USBF_RX_PACK -- requirements
Module: usbf_rx_pack

---
 rtl/usbf_rx_pkg.sv | 15 +
 rtl/usbf_rx_wfifo.sv | 56 +++++
 rtl/usbf_rx_pack.sv | 182 ++++++++++++++++++
 tb/tb_usbf_rx_pack.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbf_rx_pkg.sv
// Shared types and defaults for the USB function receive-data packer.
package usbf_rx_pkg;

    localparam int USBF_AW_DEF = 15;
    localparam int USBF_FD_DEF = 4;
    localparam int SIZE_W      = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/usbf_rx_wfifo.sv
// Word FIFO between the byte packer and the buffer-memory write port.
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
module usbf_rx_wfifo #(
    parameter int DW = 32,
    parameter int FD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam logic [PW:0] CNT_FULL = (PW+1)'(FD);

    logic [DW-1:0] r_mem [FD];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;
    logic          w_pop;
    logic          w_push;

    assign empty  = (r_cnt == '0);
    assign full   = (r_cnt == CNT_FULL);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign dout   = r_mem[r_rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Storage carries data only; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (w_push && !clr) r_mem[r_wp] <= din;
    end

endmodule

// File: rtl/usbf_rx_pack.sv
// Packs received bytes little-endian into 32-bit words and streams them to
// buffer memory through a small word FIFO with a mwe/mack handshake.
module usbf_rx_pack
    import usbf_rx_pkg::*;
#(
    parameter int AW = USBF_AW_DEF,
    parameter int FD = USBF_FD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     base_adr,
    input  logic [SIZE_W-1:0] max_size,
    input  logic              abort,
    input  logic [7:0]        rx_data_st,
    input  logic              rx_data_valid,
    input  logic              rx_data_done,
    input  logic              crc16_err,
    output logic [AW-1:0]     madr,
    output logic [31:0]       mdout,
    output logic              mwe,
    input  logic              mack,
    output logic              busy,
    output logic              done,
    output logic [SIZE_W-1:0] size,
    output logic              ovf,
    output logic              crc_err
);

    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [AW-1:0]     r_wr_adr;
    logic [SIZE_W-1:0] r_cnt;
    logic [SIZE_W-1:0] r_max;
    logic [31:0]       r_acc;
    logic              r_ovf;
    logic              r_crc_err;

    logic [SIZE_W-1:0] w_cnt_nxt;
    logic [31:0]       w_acc_nxt;
    logic [31:0]       w_acc_byte;
    logic [31:0]       w_push_data;
    logic [1:0]        w_lane;
    logic              w_push;
    logic              w_clr;
    logic              w_load;
    logic              w_byte_ovf;
    logic              w_latch_crc;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [31:0]       w_head;

    usbf_rx_wfifo #(
        .DW (32),
        .FD (FD)
    ) u_wfifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .push  (w_push),
        .din   (w_push_data),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_pop   = mack && !w_empty;
    assign mwe     = !w_empty;
    assign madr    = r_wr_adr;
    assign mdout   = w_empty ? 32'd0 : w_head;
    assign busy    = (r_state == ST_RECV) || (r_state == ST_FLUSH);
    assign done    = (r_state == ST_DONE);
    assign size    = r_cnt;
    assign ovf     = r_ovf;
    assign crc_err = r_crc_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_load      = 1'b0;
        w_push      = 1'b0;
        w_push_data = r_acc;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_byte_ovf  = 1'b0;
        w_latch_crc = 1'b0;
        w_lane      = r_cnt[1:0];
        w_acc_byte  = r_acc;
        w_acc_byte[{w_lane, 3'b000} +: 8] = rx_data_st;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (abort) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (rx_data_valid) begin
                        if (r_cnt < r_max) begin
                            w_cnt_nxt = r_cnt + 1'b1;
                            if (w_lane == 2'd3) begin
                                w_push      = 1'b1;
                                w_push_data = w_acc_byte;
                                w_acc_nxt   = '0;
                            end else begin
                                w_acc_nxt = w_acc_byte;
                            end
                        end else begin
                            w_byte_ovf = 1'b1;
                        end
                    end
                    // A partial word is pushed on the way into FLUSH; a full
                    // word completed this cycle leaves cnt[1:0]==0, so at most one push.
                    if (rx_data_done) begin
                        w_latch_crc = 1'b1;
                        w_state_nxt = ST_FLUSH;
                        if (w_cnt_nxt[1:0] != 2'd0) begin
                            w_push      = 1'b1;
                            w_push_data = w_acc_nxt;
                            w_acc_nxt   = '0;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_adr  <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_crc_err <= 1'b0;
        end else if (w_load) begin
            r_wr_adr  <= base_adr;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_crc_err <= 1'b0;
        end else begin
            if (w_pop) r_wr_adr <= r_wr_adr + 1'b1;
            r_cnt <= w_cnt_nxt;
            if (w_byte_ovf || (w_push && w_full && !w_pop)) r_ovf <= 1'b1;
            if (w_latch_crc) r_crc_err <= crc16_err;
        end
    end

    // Lane accumulator and byte limit are pure data; start reloads them.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_acc <= '0;
            r_max <= max_size;
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

endmodule

// File: tb/tb_usbf_rx_pack.sv
// Directed bench for usbf_rx_pack: packets are driven byte by byte while a
// reference model queues the expected memory writes for the write monitor.
module tb_usbf_rx_pack;

    localparam int AW = 15;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_adr;
    logic [10:0]   max_size;
    logic          abort;
    logic [7:0]    rx_data_st;
    logic          rx_data_valid;
    logic          rx_data_done;
    logic          crc16_err;
    logic [AW-1:0] madr;
    logic [31:0]   mdout;
    logic          mwe;
    logic          mack;
    logic          busy;
    logic          done;
    logic [10:0]   size;
    logic          ovf;
    logic          crc_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int mack_mode = 1;       // 0: held low, 1: held high, 2: low every third cycle
    bit stab_en   = 1'b1;

    logic [AW+31:0] sb[$];
    logic [7:0]     pkt[$];
    logic [AW+31:0] mon_ent;
    bit             prev_hold = 1'b0;
    logic [AW-1:0]  prev_adr;
    logic [31:0]    prev_dat;

    usbf_rx_pack #(.AW(AW), .FD(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .base_adr(base_adr),
        .max_size(max_size), .abort(abort), .rx_data_st(rx_data_st),
        .rx_data_valid(rx_data_valid), .rx_data_done(rx_data_done),
        .crc16_err(crc16_err), .madr(madr), .mdout(mdout), .mwe(mwe),
        .mack(mack), .busy(busy), .done(done), .size(size), .ovf(ovf),
        .crc_err(crc_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (mack_mode)
            0:       mack = 1'b0;
            1:       mack = 1'b1;
            default: mack = ((cyc % 3) != 0);
        endcase
    endtask

    // Write monitor: every accepted write must match the head of the scoreboard,
    // and a stalled request must not change before it is acknowledged.
    always @(negedge clk) begin
        if (rst === 1'b0 && mwe === 1'b1 && mack === 1'b1) begin
            if (sb.size() == 0) begin
                check("write_unexpected", 64'(mwe), 64'd0);
            end else begin
                mon_ent = sb.pop_front();
                check("wr_adr", 64'(madr), 64'(mon_ent[AW+31:32]));
                check("wr_dat", 64'(mdout), 64'(mon_ent[31:0]));
            end
        end
        if (stab_en && prev_hold) begin
            check("hold_mwe", 64'(mwe), 64'd1);
            check("hold_adr", 64'(madr), 64'(prev_adr));
            check("hold_dat", 64'(mdout), 64'(prev_dat));
        end
        prev_hold = (mwe === 1'b1 && mack === 1'b0);
        prev_adr  = madr;
        prev_dat  = mdout;
    end

    task automatic wait_done(input int exp_size, input bit exp_ovf, input bit exp_crc);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
            else tick();
        end
        check("done_seen", 64'(got), 64'd1);
        if (got) begin
            check("size", 64'(size), 64'(exp_size));
            check("ovf", 64'(ovf), 64'(exp_ovf));
            check("crc_err", 64'(crc_err), 64'(exp_crc));
            check("busy_in_done", 64'(busy), 64'd0);
            check("mwe_in_done", 64'(mwe), 64'd0);
            tick();
            @(negedge clk);
            check("done_width", 64'(done), 64'd0);
            check("size_hold", 64'(size), 64'(exp_size));
        end
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    // Drives one packet from pkt[] and queues the expected writes.
    // done_with_last folds rx_data_done into the final byte cycle.
    task automatic run_pkt(input logic [AW-1:0] base, input int maxs, input bit crc,
                           input bit done_with_last, input bit stall, input bit poke_start,
                           input int exp_size, input bit exp_ovf);
        logic [31:0]   m_acc = '0;
        int            m_cnt = 0;
        int            m_pend = 0;
        logic [AW-1:0] m_adr = base;
        start = 1'b1; base_adr = base; max_size = 11'(maxs);
        tick();
        start = 1'b0;
        for (int i = 0; i < pkt.size(); i++) begin
            rx_data_valid = 1'b1;
            rx_data_st    = pkt[i];
            if (poke_start && i == 1) begin
                start = 1'b1; base_adr = base ^ 15'h0055; max_size = 11'd1;
            end
            if (m_cnt < maxs) begin
                m_acc[8*(m_cnt%4) +: 8] = pkt[i];
                m_cnt++;
                if (m_cnt % 4 == 0) begin
                    if (stall && m_pend >= FD) begin
                    end else begin
                        sb.push_back({m_adr, m_acc}); m_adr++; m_pend++;
                    end
                    m_acc = '0;
                end
            end
            if (done_with_last && i == pkt.size() - 1) begin
                rx_data_done = 1'b1; crc16_err = crc;
            end
            tick();
            start = 1'b0; base_adr = base; max_size = 11'(maxs);
        end
        rx_data_valid = 1'b0;
        rx_data_done  = 1'b0;
        if (!done_with_last) begin
            rx_data_done = 1'b1; crc16_err = crc;
            tick();
            rx_data_done = 1'b0;
        end
        if (m_cnt % 4 != 0) sb.push_back({m_adr, m_acc});
        crc16_err = 1'b0;
        if (stall) begin
            repeat (18) tick();
            check("stall_ovf", 64'(ovf), 64'd1);
            check("stall_mwe", 64'(mwe), 64'd1);
            check("stall_busy", 64'(busy), 64'd1);
            check("stall_pending", 64'(sb.size()), 64'(FD));
            mack_mode = 1;
        end
        wait_done(exp_size, exp_ovf, crc);
    endtask

    task automatic pkt_seq(input int n, input logic [7:0] first);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(first + 8'(i));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_adr = '0; max_size = '0; abort = 1'b0;
        rx_data_st = '0; rx_data_valid = 1'b0; rx_data_done = 1'b0; crc16_err = 1'b0;
        mack = 1'b0;
        tick();
        check("rst_madr", 64'(madr), 64'd0);
        check("rst_mdout", 64'(mdout), 64'd0);
        check("rst_mwe", 64'(mwe), 64'd0);
        check("rst_size", 64'(size), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_crc", 64'(crc_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        mack_mode = 2;
        repeat (3) tick();

        // Two full words, separate done strobe.
        pkt_seq(8, 8'h01);
        run_pkt(15'h0100, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0);

        // Partial tail word, done together with last byte, stray start mid-packet.
        pkt.delete();
        pkt.push_back(8'hAA); pkt.push_back(8'hBB); pkt.push_back(8'hCC);
        pkt.push_back(8'hDD); pkt.push_back(8'hEE);
        run_pkt(15'h0200, 64, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b0);

        // Byte limit overflow with CRC error.
        pkt.push_back(8'hFF);
        run_pkt(15'h0300, 3, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1);

        // Memory stalled while a 20-byte packet arrives.
        mack_mode = 0;
        pkt_seq(20, 8'h10);
        run_pkt(15'h0400, 64, 1'b0, 1'b0, 1'b1, 1'b0, 20, 1'b1);

        // Address wrap.
        mack_mode = 2;
        pkt_seq(8, 8'h31);
        run_pkt(15'h7FFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0);

        // Abort after 6 bytes with a word pending.
        stab_en = 1'b0;
        mack_mode = 0;
        start = 1'b1; base_adr = 15'h0500; max_size = 11'd64;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_data_valid = 1'b1; rx_data_st = 8'(8'h40 + i);
            tick();
        end
        rx_data_valid = 1'b0;
        check("abort_pre_mwe", 64'(mwe), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_mwe", 64'(mwe), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        mack_mode = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'd0);
            tick();
        end

        // Reset after 6 bytes.
        mack_mode = 0;
        start = 1'b1; base_adr = 15'h0600; max_size = 11'd64;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_data_valid = 1'b1; rx_data_st = 8'(8'h60 + i);
            tick();
        end
        rx_data_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("rstmid_mwe", 64'(mwe), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_size", 64'(size), 64'd0);
        rst = 1'b0;
        mack_mode = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rstmid_no_done", 64'(done), 64'd0);
            check("rstmid_no_write", 64'(mwe), 64'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
